// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer feeding the seven-segment scan controller.
// Start/pause toggles run state; clear reloads the preset; an internal divider paces the 1 s decrement.
module countdown_timer #(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter logic [3:0]  PRESET_M1 = 4'd0,
  parameter logic [3:0]  PRESET_M0 = 4'd1,
  parameter logic [3:0]  PRESET_S1 = 4'd0,
  parameter logic [3:0]  PRESET_S0 = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pause,
  input  logic       clear,
  output logic [3:0] in3,
  output logic [3:0] in2,
  output logic [3:0] in1,
  output logic [3:0] in0,
  output logic       state,
  output logic       done
);

  localparam int unsigned    DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [15:0]    PRESET   = {PRESET_M1, PRESET_M0, PRESET_S1, PRESET_S0};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e           fsm_q, fsm_d;
  logic [15:0]      time_q, time_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             tick;
  logic [15:0]      time_dec;

  // One-second BCD decrement; the caller never applies it at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign tick     = (fsm_q == RUN) && (div_q == DIV_LAST);
  assign time_dec = bcd_dec(time_q);

  always_comb begin
    fsm_d  = fsm_q;
    time_d = time_q;
    div_d  = div_q;
    if (clear) begin
      fsm_d  = IDLE;
      time_d = PRESET;
      div_d  = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_pause) fsm_d = (PRESET == 16'h0000) ? DONE : RUN;
        end
        RUN: begin
          if (tick) begin
            div_d  = '0;
            time_d = time_dec;
            // Expiry wins over a coincident pause request.
            if (time_dec == 16'h0000) fsm_d = DONE;
            else if (start_pause)     fsm_d = PAUSE;
          end else begin
            div_d = div_q + DIV_W'(1);
            if (start_pause) fsm_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start_pause) fsm_d = RUN;
        end
        DONE: begin
          time_d = 16'h0000;
        end
        default: fsm_d = IDLE;
      endcase
    end
    run_d  = (fsm_d == RUN);
    done_d = (fsm_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      time_q <= PRESET;
      div_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      time_q <= time_d;
      div_q  <= div_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign in3   = time_q[15:12];
  assign in2   = time_q[11:8];
  assign in1   = time_q[7:4];
  assign in0   = time_q[3:0];
  assign state = run_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios followed by random pulses,
// compared each cycle against a seconds-remaining reference model.
module tb_countdown_timer;

  localparam int TD     = 4;
  localparam int PRESET = 60;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_pause = 1'b0;
  logic       clear = 1'b0;
  logic       sp_z = 1'b0;
  logic       clr_z = 1'b0;
  logic [3:0] in3, in2, in1, in0;
  logic       state, done;
  logic [3:0] z3, z2, z1, z0;
  logic       z_state, z_done;

  int n_chk  = 0;
  int n_fail = 0;
  int m_secs, m_phase, m_mode;

  countdown_timer #(.TICK_DIV(TD), .PRESET_M1(4'd0), .PRESET_M0(4'd1),
                    .PRESET_S1(4'd0), .PRESET_S0(4'd0)) u_dut (
    .clk(clk), .rst(rst), .start_pause(start_pause), .clear(clear),
    .in3(in3), .in2(in2), .in1(in1), .in0(in0), .state(state), .done(done));

  countdown_timer #(.TICK_DIV(TD), .PRESET_M1(4'd0), .PRESET_M0(4'd0),
                    .PRESET_S1(4'd0), .PRESET_S0(4'd0)) u_zero (
    .clk(clk), .rst(rst), .start_pause(sp_z), .clear(clr_z),
    .in3(z3), .in2(z2), .in1(z1), .in0(z0), .state(z_state), .done(z_done));

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] digits(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: whole seconds remaining plus RUN cycles elapsed in the current second.
  task automatic model_edge(input bit r, input bit c, input bit sp);
    if (r || c) begin
      m_secs = PRESET; m_phase = 0; m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:  if (sp) m_mode = (m_secs == 0) ? M_DONE : M_RUN;
        M_RUN: begin
          if (m_phase == TD - 1) begin
            m_phase = 0;
            m_secs  = m_secs - 1;
            if (m_secs == 0) m_mode = M_DONE;
            else if (sp)     m_mode = M_PAUSE;
          end else begin
            m_phase = m_phase + 1;
            if (sp) m_mode = M_PAUSE;
          end
        end
        M_PAUSE: if (sp) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit sp, input bit c = 0, input bit r = 0, input bit spz = 0);
    start_pause = sp; clear = c; rst = r; sp_z = spz;
    @(posedge clk);
    model_edge(r, c, sp);
    #1;
    start_pause = 0; clear = 0; rst = 0; sp_z = 0;
    chk("model digits", {in3, in2, in1, in0}, digits(m_secs));
    chk("model state", 16'(state), 16'(m_mode == M_RUN));
    chk("model done", 16'(done), 16'(m_mode == M_DONE));
  endtask

  task automatic run_until(input int target, input int budget);
    int k = 0;
    while (m_secs != target && k < budget) begin
      step(0);
      k++;
    end
    chk("reach target time", {in3, in2, in1, in0}, digits(target));
  endtask

  initial begin
    // Reset and idle hold
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset digits", {in3, in2, in1, in0}, 16'h0100);
    chk("reset state", 16'(state), 16'd0);
    chk("reset done", 16'(done), 16'd0);
    for (int i = 0; i < 20; i++) step(0);
    chk("idle hold digits", {in3, in2, in1, in0}, 16'h0100);

    // Start and first borrows
    step(1);
    chk("start state", 16'(state), 16'd1);
    for (int i = 0; i < 3; i++) step(0);
    chk("before first tick", {in3, in2, in1, in0}, 16'h0100);
    step(0);
    chk("first tick 00:59", {in3, in2, in1, in0}, 16'h0059);
    for (int i = 0; i < 4; i++) step(0);
    chk("second tick 00:58", {in3, in2, in1, in0}, 16'h0058);

    // Expiry, with pause coinciding with the final tick
    run_until(2, 400);
    for (int i = 0; i < 4; i++) step(0);
    chk("tick 00:01", {in3, in2, in1, in0}, 16'h0001);
    for (int i = 0; i < 3; i++) step(0);
    step(1);
    chk("expire digits", {in3, in2, in1, in0}, 16'h0000);
    chk("expire state", 16'(state), 16'd0);
    chk("expire done", 16'(done), 16'd1);
    step(1);
    step(0);
    chk("done ignores start", 16'(done), 16'd1);
    chk("done digits hold", {in3, in2, in1, in0}, 16'h0000);

    // Pause preserves the partial second
    step(0, 1);
    chk("clear from done", {in3, in2, in1, in0}, 16'h0100);
    step(1);
    step(0);
    step(1);
    chk("paused state", 16'(state), 16'd0);
    for (int i = 0; i < 10; i++) step(0);
    chk("pause hold digits", {in3, in2, in1, in0}, 16'h0100);
    step(1);
    chk("resume state", 16'(state), 16'd1);
    step(0);
    chk("resume +1 no tick", {in3, in2, in1, in0}, 16'h0100);
    step(0);
    chk("resume +2 tick", {in3, in2, in1, in0}, 16'h0059);

    // Clear beats start_pause mid-run
    run_until(37, 300);
    step(1, 1);
    chk("clear+start digits", {in3, in2, in1, in0}, 16'h0100);
    chk("clear+start state", 16'(state), 16'd0);
    step(1);
    for (int i = 0; i < 3; i++) step(0);
    chk("post-clear no early tick", {in3, in2, in1, in0}, 16'h0100);
    step(0);
    chk("post-clear first tick", {in3, in2, in1, in0}, 16'h0059);

    // Reset mid-run, then zero preset
    run_until(10, 300);
    step(0, 0, 1);
    chk("mid-run reset digits", {in3, in2, in1, in0}, 16'h0100);
    chk("mid-run reset state", 16'(state), 16'd0);
    chk("mid-run reset done", 16'(done), 16'd0);
    chk("zero preset idle done", 16'(z_done), 16'd0);
    step(0, 0, 0, 1);
    chk("zero preset done", 16'(z_done), 16'd1);
    chk("zero preset state", 16'(z_state), 16'd0);
    chk("zero preset digits", {z3, z2, z1, z0}, 16'h0000);

    // Random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 255) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Upstream counter stage for the four-digit seven-segment display path: a MM:SS BCD countdown timer that produces the four digit nibbles and the running/paused status bit consumed by the display scan controller. One-cycle start/pause and clear pulses come from the team's debounce/one-pulse stage. The 1 Hz decrement tick is generated internally from the system clock. All outputs are registered.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per decrement (1 s at 100 MHz); must be ≥ 2.
- `PRESET_M1`, default 4'd0: preset tens-of-minutes digit, range 0–9.
- `PRESET_M0`, default 4'd1: preset minutes digit, range 0–9.
- `PRESET_S1`, default 4'd0: preset tens-of-seconds digit, range 0–5.
- `PRESET_S0`, default 4'd0: preset seconds digit, range 0–9.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start_pause` input 1: one-cycle pulse; toggles between run and pause.
- `clear` input 1: one-cycle pulse; reloads the preset and returns to IDLE.
- `in3` output 4: BCD tens of minutes.
- `in2` output 4: BCD minutes.
- `in1` output 4: BCD tens of seconds.
- `in0` output 4: BCD seconds.
- `state` output 1: 1 while counting (RUN), 0 otherwise.
- `done` output 1: level; 1 while in DONE (time expired).

## Operation
- FSM states: IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- Reset values: digits = preset, `state` = 0, `done` = 0, divider = 0.
- IDLE:
  - `start_pause` → RUN.
  - If the preset is 00:00, `start_pause` goes directly to DONE.
- RUN:
  - Divider increments each cycle.
  - When the divider equals TICK_DIV−1, it wraps to 0 and the time decrements by one second.
  - `start_pause` → PAUSE.
- PAUSE:
  - Divider holds its value, so the partial second is preserved.
  - Digits hold.
  - `start_pause` → RUN.
- DONE:
  - Digits are 00:00. `done` = 1.
  - `start_pause` is ignored.
- `clear` in any state: digits reload the preset, divider → 0, next state IDLE.
- Decrement arithmetic (per-digit borrow chain):
  - `in0` 0→9, borrowing from `in1`.
  - `in1` 0→5, borrowing from `in2`.
  - `in2` 0→9, borrowing from `in3`.
  - `in3` never borrows, because 00:00 is caught first.
- Reaching zero: a tick at 00:01 produces 00:00 and moves RUN→DONE on the same edge.
- Digits never hold non-BCD values, and seconds never exceed 59.
- Simultaneous events:
  - `rst` beats everything.
  - `clear` beats `start_pause` and tick.
  - Tick plus `start_pause` in RUN: the decrement is applied and the FSM enters PAUSE on the same edge.
  - A tick that reaches 00:00 together with `start_pause`: the FSM enters DONE, and the pause is ignored.
- Reset or `clear` mid-run: takes effect at the next edge; no residual tick is applied afterwards.

## Timing
- All outputs change only on the rising edge of `clk`.
- `state` and `done` are decoded from the registered FSM state. Their latency from a qualifying pulse is 1 cycle.
- First decrement after the `start_pause` pulse sampled in IDLE: exactly TICK_DIV cycles later.
- Pause/resume: total RUN cycles between consecutive decrements is always TICK_DIV, regardless of time spent in PAUSE.
- Digit update latency from the tick condition: 0 extra cycles; digits change on the edge where the divider wraps.
- Pulses are assumed to be one cycle wide. A multi-cycle `start_pause` toggles every cycle it is high; this is not guarded.

## Test plan
All scenarios use TICK_DIV=4.
- Reset with preset 01:00 → digits 0,1,0,0; `state`=0; `done`=0. Digits hold for 20 cycles with no pulses.
- `start_pause` at cycle 0 → `state`=1 at cycle 1; digits 00:59 at cycle 4 and 00:58 at cycle 8. The borrow 01:00→00:59 is checked.
- Preset 00:02, run → 00:01 then 00:00. On the 00:00 edge, `state`=0 and `done`=1. A later `start_pause` changes nothing.
- Run 2 cycles, pause 10 cycles, resume → the next decrement occurs exactly 2 RUN cycles after resume. Digits hold during the pause.
- `clear` and `start_pause` on the same cycle while in RUN at 00:37 → preset reloaded, IDLE, `state`=0, divider restarts. The first tick comes 4 cycles after the next `start_pause`.
- `rst` asserted mid-RUN at 00:10 → next edge shows the preset, `state`=0, `done`=0. Preset 00:00 plus `start_pause` → DONE after 1 cycle.
